ioslot_bridge: RTL and testbench
================================

# ioslot_bridge

Parametrised, registered successor to the single-window I/O slot decoder: one CPU-side I/O port fanned out to `SLOTS` peripheral windows, with a state machine that holds the peripheral strobe until the device acknowledges. It sits between the address-space splitter and the peripheral devices. It also returns an error response for unmapped addresses and, optionally, for devices that never answer.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: CPU-side byte address width.
- `DATA_WIDTH`, 32: CPU-side data width.
- `PERIPH_DATA_WIDTH`, 32: peripheral data width, at most `DATA_WIDTH`.
- `PERIPH_ADDR_WIDTH`, 6: peripheral word-register index width.
- `SLOTS`, 4: number of peripheral windows, 1..16.
- `SLOT_BASE`, 0: byte address of slot 0.
- `SLOT_SIZE`, 256: bytes per window; power of two and at least `4<<PERIPH_ADDR_WIDTH`.
- `TIMEOUT`, 15: wait-cycle limit. Used only with the timeout feature.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `read`  in  1  CPU read request, held until `ready`.
- `write`  in  1  CPU write request, held until `ready`.
- `addr`  in  ADDR_WIDTH  CPU byte address.
- `wdata`  in  DATA_WIDTH  CPU write data.
- `rdata`  out  DATA_WIDTH  read data, valid while `ready`.
- `ready`  out  1  one-cycle completion pulse.
- `error`  out  1  qualifies `ready`: unmapped address or timeout.
- `io_addr`  out  PERIPH_ADDR_WIDTH  word index inside the selected window.
- `io_wdata`  out  PERIPH_DATA_WIDTH  peripheral write data.
- `io_rdata`  in  SLOTS*PERIPH_DATA_WIDTH  per-slot read data; slot i occupies bits [i*PERIPH_DATA_WIDTH +: PERIPH_DATA_WIDTH].
- `io_read`  out  SLOTS  one-hot read strobes.
- `io_write`  out  SLOTS  one-hot write strobes.
- `io_ready`  in  SLOTS  per-slot acknowledge.

## Operation
- Slot i window: [SLOT_BASE + i*SLOT_SIZE, SLOT_BASE + (i+1)*SLOT_SIZE). Offset = addr − base. `io_addr` = offset[PERIPH_ADDR_WIDTH+1:2]; offset bits [1:0] are ignored.
- States: IDLE, ACCESS, DONE.
- IDLE with `read` or `write` high:
  - If `read` and `write` are both high, the request is a read.
  - Address hit: latch slot index, `io_addr`, `io_wdata` (`wdata` truncated to `PERIPH_DATA_WIDTH`) and direction, then go to ACCESS.
  - Address miss: set `error`=1, `rdata`=0, go to DONE. No strobe is issued.
- ACCESS:
  - Exactly one strobe bit is high: the selected slot, in the latched direction.
  - `io_addr` and `io_wdata` are stable for the whole state.
  - When `io_ready[slot]` is sampled high, go to DONE with `error`=0. For reads, `rdata` latches that slot's `io_rdata`, zero-extended to `DATA_WIDTH`; for writes, `rdata`=0.
  - `io_ready` of unselected slots is ignored.
- DONE: `ready`=1 for exactly one cycle, then return to IDLE.
  - The requester drops `read`/`write` on the edge that ends DONE.
  - A request still high in IDLE starts a new transaction.
- All outputs are registered.

## Timing
- Reset (`rst` sampled high): state goes to IDLE. `ready`, `error`, `rdata`, `io_addr`, `io_wdata`, `io_read` and `io_write` all go to 0 on that edge. Reset applies in any state; an in-flight access is abandoned with no `ready`.
- Request sampled in IDLE at edge E: strobe is high from E. If `io_ready` is seen at edge E+k (k≥1), `ready` is high from E+k for one cycle. Minimum latency is 2 cycles from the request cycle to the `ready` cycle.
- Unmapped request at edge E: `ready` and `error` are high from E, i.e. 1-cycle latency.
- A strobe deasserts on the same edge that enters DONE.
- `rdata`, `error` and `ready` change only on the entry and exit edges of DONE. On DONE exit, `ready` and `error` return to 0 and `rdata` holds its value.

## Configuration
- `IOSLOT_TIMEOUT_EN` defined:
  - A wait counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If `io_ready` is not seen by the `TIMEOUT`-th cycle in ACCESS, the bridge drops the strobe and goes to DONE with `error`=1, `rdata`=0.
  - `io_ready` arriving on the same edge as the limit wins: normal completion.
- `IOSLOT_TIMEOUT_EN` undefined: no counter is built, `TIMEOUT` is unused, and ACCESS waits indefinitely.

## Test plan
- Read from slot 2 with SLOT_BASE=0x100, addr=0x30C; slot 2 drives `io_rdata`=0xA5, `io_ready` 3 cycles after strobe -> `io_read`=4'b0100, `io_addr`=3, strobe held 3 cycles, then `ready`=1, `rdata`=0x000000A5, `error`=0.
- Write 0xDEADBEEF to slot 0, offset 0x08, immediate `io_ready` -> `io_write`=4'b0001 for 1 cycle, `io_addr`=2, `io_wdata`=0xDEADBEEF, `ready` 2 cycles after request.
- addr=0x600 with 4 slots at base 0x100 (unmapped) -> `ready`=1, `error`=1, `rdata`=0 one cycle after request; all strobes stay 0.
- With `IOSLOT_TIMEOUT_EN`, `TIMEOUT`=15, `io_ready` never asserted -> strobe high for 15 cycles, then `ready`=1, `error`=1. Repeat with `io_ready` on cycle 15 -> `error`=0.
- `rst` asserted during ACCESS of slot 1 -> next edge: all strobes 0, `ready` 0, state IDLE. A following request completes normally.
- `read` and `write` both high, addr in slot 3 -> only `io_read[3]` asserted, never `io_write`.

Source files
------------

// File: rtl/ioslot_bridge_if.sv
// CPU-side I/O port plus the fanned-out peripheral slot bus of ioslot_bridge.
// The bridge uses the slave view; the CPU/peripheral environment uses master.
interface ioslot_bridge_if #(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned DATA_WIDTH        = 32,
    parameter int unsigned PERIPH_DATA_WIDTH = 32,
    parameter int unsigned PERIPH_ADDR_WIDTH = 6,
    parameter int unsigned SLOTS             = 4
);
    logic                                read;
    logic                                write;
    logic [ADDR_WIDTH-1:0]               addr;
    logic [DATA_WIDTH-1:0]               wdata;
    logic [DATA_WIDTH-1:0]               rdata;
    logic                                ready;
    logic                                error;
    logic [PERIPH_ADDR_WIDTH-1:0]        io_addr;
    logic [PERIPH_DATA_WIDTH-1:0]        io_wdata;
    logic [SLOTS*PERIPH_DATA_WIDTH-1:0]  io_rdata;
    logic [SLOTS-1:0]                    io_read;
    logic [SLOTS-1:0]                    io_write;
    logic [SLOTS-1:0]                    io_ready;

    modport slave (
        input  read, write, addr, wdata, io_rdata, io_ready,
        output rdata, ready, error, io_addr, io_wdata, io_read, io_write
    );

    modport master (
        output read, write, addr, wdata, io_rdata, io_ready,
        input  rdata, ready, error, io_addr, io_wdata, io_read, io_write
    );
endinterface

// File: rtl/ioslot_bridge.sv
// Registered I/O slot bridge: decodes one CPU port onto SLOTS peripheral windows.
// Define IOSLOT_TIMEOUT_EN to abort accesses that see no io_ready within TIMEOUT cycles.
module ioslot_bridge #(
    parameter int unsigned     ADDR_WIDTH        = 32,
    parameter int unsigned     DATA_WIDTH        = 32,
    parameter int unsigned     PERIPH_DATA_WIDTH = 32,
    parameter int unsigned     PERIPH_ADDR_WIDTH = 6,
    parameter int unsigned     SLOTS             = 4,
    parameter longint unsigned SLOT_BASE         = 0,
    parameter int unsigned     SLOT_SIZE         = 256,
    parameter int unsigned     TIMEOUT           = 15
) (
    input  logic             clk,
    input  logic             rst,
    ioslot_bridge_if.slave   bus
);
    localparam int unsigned SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int unsigned SLOT_SHIFT = $clog2(SLOT_SIZE);
    localparam logic [ADDR_WIDTH:0] BASE_W = (ADDR_WIDTH+1)'(SLOT_BASE);
    localparam logic [ADDR_WIDTH:0] SPAN_W = (ADDR_WIDTH+1)'(longint'(SLOTS) * SLOT_SIZE);

    if (PERIPH_DATA_WIDTH > DATA_WIDTH || SLOTS < 1 || SLOTS > 16 || TIMEOUT < 1 ||
        SLOT_SIZE < (4 << PERIPH_ADDR_WIDTH) || (SLOT_SIZE & (SLOT_SIZE - 1)) != 0) begin : g_bad_params
        $error("ioslot_bridge: illegal parameter combination");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t                       state_q;
    logic [SLOT_W-1:0]            slot_q;
    logic                         ready_q;
    logic                         error_q;
    logic [DATA_WIDTH-1:0]        rdata_q;
    logic [PERIPH_ADDR_WIDTH-1:0] io_addr_q;
    logic [PERIPH_DATA_WIDTH-1:0] io_wdata_q;
    logic [SLOTS-1:0]             io_read_q;
    logic [SLOTS-1:0]             io_write_q;

    logic [ADDR_WIDTH:0]          off_d;
    logic                         hit_d;
    logic [SLOT_W-1:0]            slot_d;
    logic [SLOTS-1:0]             sel_d;
    logic [PERIPH_ADDR_WIDTH-1:0] reg_d;

`ifdef IOSLOT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_q;
`endif

    // The extra top bit of off_d is the borrow, so addresses below SLOT_BASE miss.
    always_comb begin
        off_d  = {1'b0, bus.addr} - BASE_W;
        hit_d  = !off_d[ADDR_WIDTH] && (off_d < SPAN_W);
        slot_d = SLOT_W'(off_d >> SLOT_SHIFT);
        sel_d  = SLOTS'(1) << slot_d;
        reg_d  = off_d[PERIPH_ADDR_WIDTH+1:2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            io_read_q  <= '0;
            io_write_q <= '0;
`ifdef IOSLOT_TIMEOUT_EN
            wait_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.read || bus.write) begin
                        if (hit_d) begin
                            slot_q     <= slot_d;
                            io_addr_q  <= reg_d;
                            io_wdata_q <= bus.wdata[PERIPH_DATA_WIDTH-1:0];
                            io_read_q  <= bus.read ? sel_d : '0;
                            io_write_q <= bus.read ? '0 : sel_d;
`ifdef IOSLOT_TIMEOUT_EN
                            wait_q     <= '0;
`endif
                            state_q    <= S_ACCESS;
                        end else begin
                            ready_q <= 1'b1;
                            error_q <= 1'b1;
                            rdata_q <= '0;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_ACCESS: begin
                    if (bus.io_ready[slot_q]) begin
                        ready_q    <= 1'b1;
                        error_q    <= 1'b0;
                        rdata_q    <= (|io_read_q)
                                      ? DATA_WIDTH'(bus.io_rdata[slot_q*PERIPH_DATA_WIDTH +: PERIPH_DATA_WIDTH])
                                      : '0;
                        io_read_q  <= '0;
                        io_write_q <= '0;
                        state_q    <= S_DONE;
                    end
`ifdef IOSLOT_TIMEOUT_EN
                    // wait_q holds TIMEOUT-1 on the edge that closes the TIMEOUT-th wait cycle.
                    else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
                        ready_q    <= 1'b1;
                        error_q    <= 1'b1;
                        rdata_q    <= '0;
                        io_read_q  <= '0;
                        io_write_q <= '0;
                        state_q    <= S_DONE;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    ready_q <= 1'b0;
                    error_q <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
    assign bus.rdata    = rdata_q;
    assign bus.io_addr  = io_addr_q;
    assign bus.io_wdata = io_wdata_q;
    assign bus.io_read  = io_read_q;
    assign bus.io_write = io_write_q;
endmodule

// File: tb/tb_ioslot_bridge.sv
// Scoreboard bench for ioslot_bridge: 4 slots of 256 bytes based at 0x100.
// Timeout cases are included when IOSLOT_TIMEOUT_EN is defined.
module tb_ioslot_bridge;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned PDW = 32;
    localparam int unsigned PAW = 6;
    localparam int unsigned NS  = 4;
    localparam int unsigned TMO = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ioslot_bridge_if #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERIPH_DATA_WIDTH(PDW),
        .PERIPH_ADDR_WIDTH(PAW), .SLOTS(NS)
    ) bus ();

    ioslot_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERIPH_DATA_WIDTH(PDW),
        .PERIPH_ADDR_WIDTH(PAW), .SLOTS(NS), .SLOT_BASE(64'h100),
        .SLOT_SIZE(256), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int unsigned   edge_n;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got ready=1 at edge %0d expected no completion", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rdata", bus.rdata, e.rdata);
                    check("error", bus.error, e.err);
                    check("ready_edge", cyc, e.edge_n);
                end
            end
        end
    end

    task automatic mapped_txn(input string name, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int unsigned slot, input int unsigned ack_at,
                              input int unsigned lat, input logic [PDW-1:0] rv,
                              input logic noise, input logic [DW-1:0] exp_rdata,
                              input logic exp_err, input logic [NS-1:0] exp_rd,
                              input logic [NS-1:0] exp_wr, input logic [PAW-1:0] exp_ioaddr,
                              input logic [PDW-1:0] exp_iowd);
        exp_t           e;
        logic           ok;
        logic [NS-1:0]  sel;
        @(negedge clk);
        bus.io_rdata[slot*PDW +: PDW] = rv;
        sel       = NS'(1) << slot;
        bus.read  = rd;
        bus.write = wr;
        bus.addr  = a;
        bus.wdata = wd;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.edge_n  = cyc + 1 + lat;
        exp_q.push_back(e);
        ok = 1'b1;
        for (int unsigned j = 1; j <= lat; j++) begin
            @(negedge clk);
            if (bus.io_read !== exp_rd || bus.io_write !== exp_wr ||
                bus.io_addr !== exp_ioaddr || bus.io_wdata !== exp_iowd)
                ok = 1'b0;
            bus.io_ready = noise ? ~sel : '0;
            if (j == ack_at)
                bus.io_ready[slot] = 1'b1;
        end
        check({name, "_strobe"}, ok, 1);
        @(negedge clk);
        check({name, "_strobe_off"}, {bus.io_read, bus.io_write}, 0);
        bus.io_ready = '0;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        @(negedge clk);
    endtask

    task automatic unmapped_txn(input string name, input logic [AW-1:0] a);
        exp_t e;
        @(negedge clk);
        bus.read  = 1'b1;
        bus.write = 1'b0;
        bus.addr  = a;
        e.rdata   = '0;
        e.err     = 1'b1;
        e.edge_n  = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        check({name, "_no_strobe"}, {bus.io_read, bus.io_write}, 0);
        bus.read = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus expected completion within time limit");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        bus.io_ready = '0;
        bus.io_rdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        repeat (3) @(negedge clk);
        check("rst_ready",  bus.ready, 0);
        check("rst_error",  bus.error, 0);
        check("rst_rdata",  bus.rdata, 0);
        check("rst_strobe", {bus.io_read, bus.io_write}, 0);
        check("rst_io",     {bus.io_addr, bus.io_wdata}, 0);
        rst = 1'b0;

        mapped_txn("rd_slot2", 1, 0, 32'h30C, 32'h0, 2, 3, 3, 32'hA5, 0,
                   32'h000000A5, 0, 4'b0100, 4'b0000, 6'd3, 32'h0);
        unmapped_txn("unmapped_600", 32'h600);
        mapped_txn("wr_slot0", 0, 1, 32'h108, 32'hDEADBEEF, 0, 1, 1, 32'h11111111, 0,
                   32'h0, 0, 4'b0000, 4'b0001, 6'd2, 32'hDEADBEEF);
        mapped_txn("rd_slot1_top", 1, 0, 32'h2FF, 32'h0, 1, 1, 1, 32'h12345678, 0,
                   32'h12345678, 0, 4'b0010, 4'b0000, 6'h3F, 32'h0);
        unmapped_txn("unmapped_500", 32'h500);
        mapped_txn("rdwr_slot3", 1, 1, 32'h4F8, 32'h0BADF00D, 3, 2, 2, 32'h5A5A0003, 1,
                   32'h5A5A0003, 0, 4'b1000, 4'b0000, 6'h3E, 32'h0BADF00D);
        unmapped_txn("unmapped_0FF", 32'h0FF);
        mapped_txn("rd_last_byte", 1, 0, 32'h4FF, 32'h0, 3, 1, 1, 32'h00000009, 0,
                   32'h00000009, 0, 4'b1000, 4'b0000, 6'h3F, 32'h0);

        // Reset while slot 1 is mid-access: no ready may follow.
        @(negedge clk);
        bus.read  = 1'b1;
        bus.addr  = 32'h214;
        bus.wdata = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        check("pre_rst_strobe", bus.io_read, 4'b0010);
        rst      = 1'b1;
        bus.read = 1'b0;
        @(negedge clk);
        check("mid_rst_strobe", {bus.io_read, bus.io_write}, 0);
        check("mid_rst_ready",  {bus.ready, bus.error}, 0);
        check("mid_rst_rdata",  bus.rdata, 0);
        check("mid_rst_io",     {bus.io_addr, bus.io_wdata}, 0);
        rst = 1'b0;
        mapped_txn("post_rst_rd", 1, 0, 32'h214, 32'h0, 1, 2, 2, 32'h0000BEEF, 0,
                   32'h0000BEEF, 0, 4'b0010, 4'b0000, 6'd5, 32'h0);

`ifdef IOSLOT_TIMEOUT_EN
        mapped_txn("tmo_never", 1, 0, 32'h100, 32'h0, 0, 0, TMO, 32'h77, 1,
                   32'h0, 1, 4'b0001, 4'b0000, 6'd0, 32'h0);
        mapped_txn("tmo_edge", 1, 0, 32'h100, 32'h0, 0, TMO, TMO, 32'h88, 0,
                   32'h88, 0, 4'b0001, 4'b0000, 6'd0, 32'h0);
`endif

        repeat (4) @(negedge clk);
        check("pending_expect", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
